// File: rtl/sort_oet_iter.sv
// Iterative odd-even transposition sorter: one compare-exchange phase per cycle,
// stable (equal keys never swap), valid/ready on both input and output.
module sort_oet_iter #(
    parameter int NUM         = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3,
    parameter int SIGNED      = 0,
    parameter int ASCENDING   = 1,
    parameter int EARLY_EXIT  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic [NUM*DATA_WIDTH-1:0]    x_data,
    input  logic [NUM*LABEL_WIDTH-1:0]   x_label,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic [NUM*DATA_WIDTH-1:0]    y_data,
    output logic [NUM*LABEL_WIDTH-1:0]   y_label,
    output logic                         busy,
    output logic [1:0]                   state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // x_ready is high only in IDLE (and low during reset), y_valid only in DONE, where
    // y_data/y_label are held until the transfer.
    localparam int KW = $clog2(NUM + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   prev_q, prev_d;
    logic [DATA_WIDTH-1:0]  key_q [NUM];
    logic [DATA_WIDTH-1:0]  key_s [NUM];
    logic [LABEL_WIDTH-1:0] lab_q [NUM];
    logic [LABEL_WIDTH-1:0] lab_s [NUM];
    logic                   any_swap;

    function automatic logic out_of_order(input logic [DATA_WIDTH-1:0] a,
                                          input logic [DATA_WIDTH-1:0] b);
        logic gt_ab;
        logic gt_ba;
        if (SIGNED != 0) begin
            gt_ab = $signed(a) > $signed(b);
            gt_ba = $signed(b) > $signed(a);
        end else begin
            gt_ab = a > b;
            gt_ba = b > a;
        end
        return (ASCENDING != 0) ? gt_ab : gt_ba;
    endfunction

    // Pairs of one phase are disjoint, so every pair reads the registered lanes.
    always_comb begin
        any_swap = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            key_s[i] = key_q[i];
            lab_s[i] = lab_q[i];
        end
        for (int i = 0; i < NUM - 1; i++) begin
            if ((i % 2) == int'(k_q[0]) && out_of_order(key_q[i], key_q[i+1])) begin
                key_s[i]   = key_q[i+1];
                key_s[i+1] = key_q[i];
                lab_s[i]   = lab_q[i+1];
                lab_s[i+1] = lab_q[i];
                any_swap   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        prev_d  = prev_q;
        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    state_d = SORT;
                    k_d     = '0;
                    prev_d  = 1'b0;
                end
            end
            SORT: begin
                if (k_q == KW'(NUM - 1)) begin
                    state_d = DONE;
                end else if (EARLY_EXIT != 0 && k_q != '0 && !any_swap && prev_q) begin
                    state_d = DONE;
                end else begin
                    k_d    = k_q + KW'(1);
                    prev_d = !any_swap;
                end
            end
            DONE: begin
                if (y_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            prev_q  <= prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                key_q[i] <= '0;
                lab_q[i] <= '0;
            end
        end else if (state_q == IDLE && x_valid) begin
            for (int i = 0; i < NUM; i++) begin
                key_q[i] <= x_data[i*DATA_WIDTH +: DATA_WIDTH];
                lab_q[i] <= x_label[i*LABEL_WIDTH +: LABEL_WIDTH];
            end
        end else if (state_q == SORT) begin
            for (int i = 0; i < NUM; i++) begin
                key_q[i] <= key_s[i];
                lab_q[i] <= lab_s[i];
            end
        end
    end

    always_comb begin
        y_data  = '0;
        y_label = '0;
        for (int i = 0; i < NUM; i++) begin
            y_data[i*DATA_WIDTH +: DATA_WIDTH]    = key_q[i];
            y_label[i*LABEL_WIDTH +: LABEL_WIDTH] = lab_q[i];
        end
    end

    assign x_ready   = (state_q == IDLE) && !rst;
    assign y_valid   = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_sort_oet_iter.sv
// Bench for sort_oet_iter: three instances (unsigned ascending, signed descending,
// early exit) driven with directed and random vectors against a rank-based stable-sort model.
module tb_sort_oet_iter;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x_valid_a [3];
    logic          x_ready_a [3];
    logic [63:0]   x_data_a  [3];
    logic [23:0]   x_label_a [3];
    logic          y_valid_a [3];
    logic          y_ready_a [3];
    logic [63:0]   y_data_a  [3];
    logic [23:0]   y_label_a [3];
    logic          busy_a    [3];
    logic [1:0]    state_a   [3];

    bit            sgn_cfg [3] = '{1'b0, 1'b1, 1'b0};
    bit            asc_cfg [3] = '{1'b1, 1'b0, 1'b1};

    logic [87:0]   exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    sort_oet_iter #(.NUM(N), .DATA_WIDTH(DW), .LABEL_WIDTH(LW),
                    .SIGNED(0), .ASCENDING(1), .EARLY_EXIT(0)) u_dut (
        .clk(clk), .rst(rst), .x_valid(x_valid_a[0]), .x_ready(x_ready_a[0]),
        .x_data(x_data_a[0]), .x_label(x_label_a[0]), .y_valid(y_valid_a[0]),
        .y_ready(y_ready_a[0]), .y_data(y_data_a[0]), .y_label(y_label_a[0]),
        .busy(busy_a[0]), .state_dbg(state_a[0]));

    sort_oet_iter #(.NUM(N), .DATA_WIDTH(DW), .LABEL_WIDTH(LW),
                    .SIGNED(1), .ASCENDING(0), .EARLY_EXIT(0)) u_sd (
        .clk(clk), .rst(rst), .x_valid(x_valid_a[1]), .x_ready(x_ready_a[1]),
        .x_data(x_data_a[1]), .x_label(x_label_a[1]), .y_valid(y_valid_a[1]),
        .y_ready(y_ready_a[1]), .y_data(y_data_a[1]), .y_label(y_label_a[1]),
        .busy(busy_a[1]), .state_dbg(state_a[1]));

    sort_oet_iter #(.NUM(N), .DATA_WIDTH(DW), .LABEL_WIDTH(LW),
                    .SIGNED(0), .ASCENDING(1), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .x_valid(x_valid_a[2]), .x_ready(x_ready_a[2]),
        .x_data(x_data_a[2]), .x_label(x_label_a[2]), .y_valid(y_valid_a[2]),
        .y_ready(y_ready_a[2]), .y_data(y_data_a[2]), .y_label(y_label_a[2]),
        .busy(busy_a[2]), .state_dbg(state_a[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stable sort by rank: a key's output lane is the number of keys strictly
    // ahead of it plus the number of equal keys that came from lower lanes.
    function automatic void model_sort(input logic [63:0] d, input logic [23:0] l,
                                       input bit sg, input bit asc,
                                       output logic [63:0] od, output logic [23:0] ol);
        int v [N];
        int r;
        od = '0;
        ol = '0;
        for (int i = 0; i < N; i++)
            v[i] = sg ? int'($signed(d[i*DW +: DW])) : int'(d[i*DW +: DW]);
        for (int i = 0; i < N; i++) begin
            r = 0;
            for (int j = 0; j < N; j++) begin
                if (asc ? (v[j] < v[i]) : (v[j] > v[i])) r++;
                else if (v[j] == v[i] && j < i) r++;
            end
            od[r*DW +: DW] = d[i*DW +: DW];
            ol[r*LW +: LW] = l[i*LW +: LW];
        end
    endfunction

    function automatic logic [23:0] lane_labels();
        logic [23:0] l;
        for (int i = 0; i < N; i++) l[i*LW +: LW] = LW'(i);
        return l;
    endfunction

    // Waits (bounded) for y_valid; lat counts edges from the acceptance edge inclusive.
    task automatic wait_out(input int u, inout int lat);
        while (!y_valid_a[u] && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input int u, input string tag,
                             output logic [63:0] gd, output logic [23:0] gl);
        logic [87:0] e;
        gd = y_data_a[u];
        gl = y_label_a[u];
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_keys"}, gd, e[63:0]);
            check({tag, "_labels"}, {40'd0, gl}, {40'd0, e[87:64]});
        end
    endtask

    task automatic run_vec(input int u, input logic [63:0] d, input logic [23:0] l,
                           input int lat_lo, input int lat_hi, input string tag,
                           output logic [63:0] gd, output logic [23:0] gl);
        logic [63:0] ed;
        logic [23:0] el;
        int          lat;
        int          guard;
        model_sort(d, l, sgn_cfg[u], asc_cfg[u], ed, el);
        exp_q.push_back({el, ed});
        @(negedge clk);
        guard = 0;
        while (!x_ready_a[u] && guard < 40) begin
            @(negedge clk); guard++;
        end
        check({tag, "_x_ready"}, {63'd0, x_ready_a[u]}, 64'd1);
        x_valid_a[u] = 1'b1;
        x_data_a[u]  = d;
        x_label_a[u] = l;
        @(posedge clk); lat = 1;
        @(negedge clk);
        x_valid_a[u] = 1'b0;
        x_data_a[u]  = $urandom();
        wait_out(u, lat);
        check({tag, "_lat_ok"}, {63'd0, (lat >= lat_lo && lat <= lat_hi)}, 64'd1);
        if (lat < lat_lo || lat > lat_hi) $display("  %s latency %0d", tag, lat);
        pop_check(u, tag, gd, gl);
        y_ready_a[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        y_ready_a[u] = 1'b0;
        check({tag, "_idle_after"}, {62'd0, busy_a[u], y_valid_a[u]}, 64'd0);
    endtask

    initial begin
        logic [63:0] d, gd, rev, srt, nd;
        logic [23:0] l, gl, nl, el;
        logic [63:0] ed;
        int          lat;
        for (int u = 0; u < 3; u++) begin
            x_valid_a[u] = 1'b0; x_data_a[u] = '0; x_label_a[u] = '0; y_ready_a[u] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            rev[i*DW +: DW] = DW'(N - 1 - i);
            srt[i*DW +: DW] = DW'(i);
        end
        l = lane_labels();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_x_ready_low", {63'd0, x_ready_a[0]}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_x_ready_high", {63'd0, x_ready_a[0]}, 64'd1);
        check("rst_y_valid", {63'd0, y_valid_a[0]}, 64'd0);
        check("rst_busy", {63'd0, busy_a[0]}, 64'd0);
        check("rst_y_data", y_data_a[0], 64'd0);
        check("rst_y_label", {40'd0, y_label_a[0]}, 64'd0);

        // directed vectors
        run_vec(0, rev, l, 9, 9, "reverse", gd, gl);
        check("reverse_keys_const", gd, 64'h07060504_03020100);
        check("reverse_labels_const", {40'd0, gl}, {40'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
        run_vec(0, {8{8'd5}}, l, 9, 9, "all_equal", gd, gl);
        check("all_equal_labels_const", {40'd0, gl}, {40'd0, l});
        run_vec(0, {4{8'd1, 8'd3}}, l, 9, 9, "stable31", gd, gl);
        check("stable31_keys_const", gd, 64'h03030303_01010101);
        check("stable31_labels_const", {40'd0, gl},
              {40'd0, 3'd6, 3'd4, 3'd2, 3'd0, 3'd7, 3'd5, 3'd3, 3'd1});
        run_vec(1, 64'hF0_10_81_01_00_FF_7F_80, l, 9, 9, "signed_desc", gd, gl);
        check("signed_desc_keys_const", gd, 64'h80_81_F0_FF_00_01_10_7F);
        run_vec(2, srt, l, 3, 3, "ee_sorted", gd, gl);
        check("ee_sorted_keys_const", gd, srt);
        run_vec(2, rev, l, 9, 9, "ee_reverse", gd, gl);

        // random vectors, narrow key range on some to force duplicates
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++)
                d[i*DW +: DW] = (t % 2 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 3));
            l = LW*N'($urandom());
            if (t % 3 == 2) run_vec(2, d, l, 3, 9, "rand_ee", gd, gl);
            else            run_vec(t % 3, d, l, 9, 9, "rand", gd, gl);
        end

        // back-pressure in DONE with a competing input vector
        l = lane_labels();
        d = 64'h11_99_22_88_33_77_44_66;
        model_sort(d, l, 1'b0, 1'b1, ed, el);
        nd = 64'h0A_0B_0C_0D_01_02_03_04;
        nl = 24'hABCDEF;
        @(negedge clk);
        x_valid_a[0] = 1'b1; x_data_a[0] = d; x_label_a[0] = l;
        @(posedge clk); lat = 1;
        @(negedge clk);
        x_valid_a[0] = 1'b0;
        wait_out(0, lat);
        check("bp_lat", lat, 64'd9);
        for (int c = 0; c < 10; c++) begin
            x_valid_a[0] = c[0]; x_data_a[0] = nd; x_label_a[0] = nl;
            @(posedge clk);
            @(negedge clk);
            check("bp_y_data", y_data_a[0], ed);
            check("bp_y_label", {40'd0, y_label_a[0]}, {40'd0, el});
            check("bp_hold", {62'd0, y_valid_a[0], x_ready_a[0]}, 64'd2);
        end
        x_valid_a[0] = 1'b1;
        y_ready_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        y_ready_a[0] = 1'b0;
        check("bp_release_idle", {62'd0, busy_a[0], x_ready_a[0]}, 64'd1);
        model_sort(nd, nl, 1'b0, 1'b1, ed, el);
        exp_q.push_back({el, ed});
        @(posedge clk); lat = 1;
        @(negedge clk);
        x_valid_a[0] = 1'b0;
        check("bp_loaded_busy", {63'd0, busy_a[0]}, 64'd1);
        wait_out(0, lat);
        check("bp_new_lat", lat, 64'd9);
        pop_check(0, "bp_new", gd, gl);
        y_ready_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        y_ready_a[0] = 1'b0;

        // reset during the fourth SORT cycle
        @(negedge clk);
        x_valid_a[0] = 1'b1; x_data_a[0] = rev; x_label_a[0] = lane_labels();
        @(posedge clk);
        @(negedge clk);
        x_valid_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_busy_before_rst", {63'd0, busy_a[0]}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_idle", {62'd0, busy_a[0], y_valid_a[0]}, 64'd0);
        check("mid_rst_keys", y_data_a[0], 64'd0);
        check("mid_rst_labels", {40'd0, y_label_a[0]}, 64'd0);
        check("mid_rst_x_ready_low", {63'd0, x_ready_a[0]}, 64'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_x_ready_high", {63'd0, x_ready_a[0]}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_output", {63'd0, y_valid_a[0]}, 64'd0);
        end
        run_vec(0, 64'h05_03_08_01_07_02_06_04, lane_labels(), 9, 9, "post_rst", gd, gl);
        check("post_rst_keys_const", gd, 64'h08_07_06_05_04_03_02_01);

        check("sb_drained", exp_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
